// File: rtl/aes_sbox_pkg.sv
// rtl/aes_sbox_pkg.sv - shared constants, FSM/grant encodings and helpers for the S-box scheduler
//
// Purpose: common definitions imported by the S-box lane bank, the scheduler
// interface and the scheduler itself.
package aes_sbox_pkg;

    localparam int LANES    = 4;                 // S-box instances = bytes per beat
    localparam int BYTE_W   = 8;
    localparam int WORD_W   = LANES * BYTE_W;    // one beat through the lanes
    localparam int STATE_W  = 128;               // AES state
    localparam int ST_BEATS = 16 / LANES;        // beats per SubBytes
    localparam int BEAT_W   = $clog2(ST_BEATS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ST_RUN = 2'd1,
        KS_RUN = 2'd2
    } sched_state_t;

    typedef enum logic {
        GRANT_ST = 1'b0,
        GRANT_KS = 1'b1
    } grant_t;

    // Word idx of the state: bytes 4*idx .. 4*idx+3.
    function automatic logic [WORD_W-1:0] state_word(input logic [STATE_W-1:0] s,
                                                     input logic [BEAT_W-1:0]  idx);
        return s[int'(idx) * WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/sbox_scheduler_if.sv
// rtl/sbox_scheduler_if.sv - request/response bundle between AES clients and the S-box scheduler
//
// Purpose: groups the state (SubBytes) and key (SubWord) request channels.
// master: the round controller / key scheduler side (drives req and data).
// slave : the scheduler side (drives ack, done, results and busy).
interface sbox_scheduler_if;
    import aes_sbox_pkg::*;

    logic               st_req;
    logic [STATE_W-1:0] st_in;
    logic               st_ack;
    logic               st_done;
    logic [STATE_W-1:0] st_out;

    logic               ks_req;
    logic [WORD_W-1:0]  ks_in;
    logic               ks_ack;
    logic               ks_done;
    logic [WORD_W-1:0]  ks_out;

    logic               busy;

    modport master (
        output st_req, st_in, ks_req, ks_in,
        input  st_ack, st_done, st_out, ks_ack, ks_done, ks_out, busy
    );

    modport slave (
        input  st_req, st_in, ks_req, ks_in,
        output st_ack, st_done, st_out, ks_ack, ks_done, ks_out, busy
    );

endinterface

// File: rtl/sbox.sv
// rtl/sbox.sv - AES forward S-box, one byte, combinational
//
// Ports: a (byte in), y (S(a)).
module sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Row 0x0 is the most significant 128 bits; entry n sits at bits
    // [(255-n)*8 +: 8], and 255-n == ~n for an 8-bit index.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777b_f26b6fc5_3001672b_fed7ab76,
        128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
        128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
        128'h04c723c3_1896059a_071280e2_eb27b275,
        128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
        128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
        128'hd0efaafb_434d3385_45f9027f_503c9fa8,
        128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
        128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
        128'h60814fdc_222a9088_46eeb814_de5e0bdb,
        128'he0323a0a_4906245c_c2d3ac62_9195e479,
        128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
        128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
        128'h703eb566_4803f60e_613557b9_86c11d9e,
        128'he1f89811_69d98e94_9b1e87e9_ce5528df,
        128'h8ca1890d_bfe64268_41992d0f_b054bb16
    };

    assign y = SBOX_TABLE[{~a, 3'b000} +: 8];

endmodule

// File: rtl/sbox_lane4.sv
// rtl/sbox_lane4.sv - LANES parallel S-boxes on one word, combinational
//
// Ports: word_in (LANES bytes, byte j = word_in[8j+7:8j]), word_out (byte j = S(byte j)).
module sbox_lane4
    import aes_sbox_pkg::*;
(
    input  logic [WORD_W-1:0] word_in,
    output logic [WORD_W-1:0] word_out
);

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        sbox u_sbox (
            .a (word_in[j*BYTE_W +: BYTE_W]),
            .y (word_out[j*BYTE_W +: BYTE_W])
        );
    end

endmodule

// File: rtl/sbox_scheduler.sv
// rtl/sbox_scheduler.sv - time-multiplexes one 4-lane S-box bank between SubBytes and SubWord
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high
//   bus   - sbox_scheduler_if.slave: st_req/st_in -> st_ack/st_done/st_out,
//           ks_req/ks_in -> ks_ack/ks_done/ks_out, busy
// A state request takes 4 lane beats (capture->done 4 cycles), a key request
// one beat. Both requesters are level-held until ack; all outputs are registers.
module sbox_scheduler
    import aes_sbox_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    sbox_scheduler_if.slave bus
);

    sched_state_t        state_q, state_d;
    logic [BEAT_W-1:0]   beat_q;
    grant_t              last_grant_q;

    logic [STATE_W-1:0]  st_buf_q;
    logic [WORD_W-1:0]   ks_buf_q;
    logic [STATE_W-1:0]  st_out_q;
    logic [WORD_W-1:0]   ks_out_q;
    logic                st_ack_q, st_done_q, ks_ack_q, ks_done_q;

    logic                grant_st, grant_ks, upd_grant;
    logic                st_word_we, st_finish, ks_we;
    logic [WORD_W-1:0]   lane_in, lane_out;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, arbitration and lane input mux
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        grant_st   = 1'b0;
        grant_ks   = 1'b0;
        upd_grant  = 1'b0;
        st_word_we = 1'b0;
        st_finish  = 1'b0;
        ks_we      = 1'b0;
        lane_in    = '0;

        case (state_q)
            IDLE: begin
                if (bus.st_req && bus.ks_req) begin
                    // Only contested decisions move the priority flag, so the
                    // loser's later uncontested grant does not cost it the next tie.
                    upd_grant = 1'b1;
                    if (last_grant_q == GRANT_KS) begin
                        grant_st = 1'b1;
                    end else begin
                        grant_ks = 1'b1;
                    end
                end else if (bus.st_req) begin
                    grant_st = 1'b1;
                end else if (bus.ks_req) begin
                    grant_ks = 1'b1;
                end

                if (grant_st) begin
                    state_d = ST_RUN;
                end else if (grant_ks) begin
                    state_d = KS_RUN;
                end
            end

            ST_RUN: begin
                lane_in    = state_word(st_buf_q, beat_q);
                st_word_we = 1'b1;
                if (beat_q == BEAT_W'(ST_BEATS - 1)) begin
                    st_finish = 1'b1;
                    state_d   = IDLE;
                end
            end

            KS_RUN: begin
                lane_in = ks_buf_q;
                ks_we   = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    sbox_lane4 u_lanes (
        .word_in  (lane_in),
        .word_out (lane_out)
    );

    // ------------------------------------------------------------------
    // Buffers, beat counter, result and handshake registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_q       <= '0;
            last_grant_q <= GRANT_KS;
            st_buf_q     <= '0;
            ks_buf_q     <= '0;
            st_out_q     <= '0;
            ks_out_q     <= '0;
            st_ack_q     <= 1'b0;
            st_done_q    <= 1'b0;
            ks_ack_q     <= 1'b0;
            ks_done_q    <= 1'b0;
        end else begin
            st_ack_q  <= grant_st;
            ks_ack_q  <= grant_ks;
            st_done_q <= st_finish;
            ks_done_q <= ks_we;

            if (grant_st) begin
                st_buf_q <= bus.st_in;
                beat_q   <= '0;
            end

            if (grant_ks) begin
                ks_buf_q <= bus.ks_in;
            end

            if (upd_grant) begin
                last_grant_q <= grant_st ? GRANT_ST : GRANT_KS;
            end

            if (st_word_we) begin
                st_out_q[int'(beat_q) * WORD_W +: WORD_W] <= lane_out;
                beat_q <= st_finish ? '0 : beat_q + 1'b1;
            end

            if (ks_we) begin
                ks_out_q <= lane_out;
            end
        end
    end

    assign bus.st_ack  = st_ack_q;
    assign bus.st_done = st_done_q;
    assign bus.st_out  = st_out_q;
    assign bus.ks_ack  = ks_ack_q;
    assign bus.ks_done = ks_done_q;
    assign bus.ks_out  = ks_out_q;
    assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_scheduler.sv
// tb/tb_sbox_scheduler.sv - directed self-checking bench for sbox_scheduler
module tb_sbox_scheduler;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    sbox_scheduler_if bus ();

    sbox_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] ST_ZERO  = 128'h0;
    localparam logic [127:0] ST_63    = {16{8'h63}};
    localparam logic [127:0] ST_00_0F = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] SB_00_0F = 128'h76ABD7FE_2B670130_C56F6BF2_7B777C63;
    localparam logic [127:0] ST_10_1F = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
    localparam logic [127:0] SB_10_1F = 128'hC072A49C_AFA2D4AD_F04759FA_7DC982CA;
    localparam logic [31:0]  KS_A     = 32'h5301FF00;
    localparam logic [31:0]  KS_A_SB  = 32'hED7C1663;
    localparam logic [31:0]  KS_B     = 32'h0F0E0D0C;
    localparam logic [31:0]  KS_B_SB  = 32'h76ABD7FE;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".st_ack"},  {127'b0, bus.st_ack},  128'd0);
        chk({tag, ".st_done"}, {127'b0, bus.st_done}, 128'd0);
        chk({tag, ".ks_ack"},  {127'b0, bus.ks_ack},  128'd0);
        chk({tag, ".ks_done"}, {127'b0, bus.ks_done}, 128'd0);
        chk({tag, ".busy"},    {127'b0, bus.busy},    128'd0);
        chk({tag, ".st_out"},  bus.st_out,            128'd0);
        chk({tag, ".ks_out"},  {96'b0, bus.ks_out},   128'd0);
    endtask

    initial begin
        int busy_cycles;
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        bus.st_req = 1'b0;
        bus.st_in  = '0;
        bus.ks_req = 1'b0;
        bus.ks_in  = '0;

        tick();
        tick();
        chk_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // ---- state request, all-zero input ----
        bus.st_req = 1'b1;
        bus.st_in  = ST_ZERO;
        tick();                                     // E0
        chk("st0.ack", {127'b0, bus.st_ack}, 128'd1);
        busy_cycles = bus.busy ? 1 : 0;
        bus.st_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();                                 // E1..E4
            if (bus.busy) busy_cycles++;
            chk($sformatf("st0.done_e%0d", i), {127'b0, bus.st_done}, {127'b0, (i == 4)});
            chk($sformatf("st0.ack_e%0d", i), {127'b0, bus.st_ack}, 128'd0);
        end
        chk("st0.out", bus.st_out, ST_63);
        chk("st0.busy_cycles", busy_cycles, 4);
        tick();                                     // E5
        chk("st0.done_e5", {127'b0, bus.st_done}, 128'd0);

        // ---- key request ----
        bus.ks_req = 1'b1;
        bus.ks_in  = KS_A;
        tick();
        chk("ks0.ack", {127'b0, bus.ks_ack}, 128'd1);
        chk("ks0.busy", {127'b0, bus.busy}, 128'd1);
        bus.ks_req = 1'b0;
        tick();
        chk("ks0.done", {127'b0, bus.ks_done}, 128'd1);
        chk("ks0.out", {96'b0, bus.ks_out}, {96'b0, KS_A_SB});
        chk("ks0.busy_after", {127'b0, bus.busy}, 128'd0);
        tick();

        // ---- conflict pair 1: state wins, st_in changed after ack ----
        bus.st_req = 1'b1;
        bus.st_in  = ST_00_0F;
        bus.ks_req = 1'b1;
        bus.ks_in  = KS_B;
        tick();                                     // E0
        chk("p1.st_ack", {127'b0, bus.st_ack}, 128'd1);
        chk("p1.ks_ack_e0", {127'b0, bus.ks_ack}, 128'd0);
        bus.st_req = 1'b0;
        bus.st_in  = {16{8'hFF}};
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("p1.ks_wait_e%0d", i), {127'b0, bus.ks_ack}, 128'd0);
        end
        chk("p1.st_done", {127'b0, bus.st_done}, 128'd1);
        chk("p1.st_out", bus.st_out, SB_00_0F);
        tick();                                     // E5
        chk("p1.ks_ack_e5", {127'b0, bus.ks_ack}, 128'd1);
        bus.ks_req = 1'b0;
        tick();
        chk("p1.ks_done", {127'b0, bus.ks_done}, 128'd1);
        chk("p1.ks_out", {96'b0, bus.ks_out}, {96'b0, KS_B_SB});
        chk("p1.st_out_held", bus.st_out, SB_00_0F);
        tick();

        // ---- conflict pair 2: key wins ----
        bus.st_req = 1'b1;
        bus.st_in  = ST_ZERO;
        bus.ks_req = 1'b1;
        bus.ks_in  = KS_A;
        tick();
        chk("p2.ks_ack", {127'b0, bus.ks_ack}, 128'd1);
        chk("p2.st_ack_e0", {127'b0, bus.st_ack}, 128'd0);
        bus.ks_req = 1'b0;
        tick();
        chk("p2.ks_done", {127'b0, bus.ks_done}, 128'd1);
        chk("p2.ks_out", {96'b0, bus.ks_out}, {96'b0, KS_A_SB});
        chk("p2.st_ack_e1", {127'b0, bus.st_ack}, 128'd0);
        tick();                                     // E2
        chk("p2.st_ack_e2", {127'b0, bus.st_ack}, 128'd1);
        bus.st_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("p2.st_done", {127'b0, bus.st_done}, 128'd1);
        chk("p2.st_out", bus.st_out, ST_63);
        tick();

        // ---- reset at beat 2 of a state run ----
        bus.st_req = 1'b1;
        bus.st_in  = ST_00_0F;
        tick();                                     // E0
        chk("rst.ack", {127'b0, bus.st_ack}, 128'd1);
        bus.st_req = 1'b0;
        tick();                                     // E1
        tick();                                     // E2, beat 2 pending
        reset = 1'b1;
        #1;
        chk_idle_outputs("rst.mid");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rst.no_done_%0d", i), {127'b0, bus.st_done}, 128'd0);
        end
        bus.st_req = 1'b1;
        bus.st_in  = ST_10_1F;
        tick();
        chk("rst.new_ack", {127'b0, bus.st_ack}, 128'd1);
        bus.st_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("rst.new_done", {127'b0, bus.st_done}, 128'd1);
        chk("rst.new_out", bus.st_out, SB_10_1F);
        tick();

        // ---- key request held during a state run ----
        bus.st_req = 1'b1;
        bus.st_in  = ST_ZERO;
        tick();                                     // E0
        chk("hold.st_ack", {127'b0, bus.st_ack}, 128'd1);
        bus.st_req = 1'b0;
        bus.ks_req = 1'b1;
        bus.ks_in  = KS_A;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("hold.ks_wait_e%0d", i), {127'b0, bus.ks_ack}, 128'd0);
        end
        chk("hold.st_done", {127'b0, bus.st_done}, 128'd1);
        chk("hold.st_out", bus.st_out, ST_63);
        tick();                                     // E5
        chk("hold.ks_ack", {127'b0, bus.ks_ack}, 128'd1);
        bus.ks_req = 1'b0;
        tick();
        chk("hold.ks_done", {127'b0, bus.ks_done}, 128'd1);
        chk("hold.ks_out", {96'b0, bus.ks_out}, {96'b0, KS_A_SB});
        tick();
        chk("hold.busy_end", {127'b0, bus.busy}, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sbox_scheduler.md
# sbox_scheduler

Time-multiplexes a bank of four combinational `sbox` lanes between the AES-256 round datapath (16-byte SubBytes) and the key-expansion unit (4-byte SubWord). Each request is captured, arbitrated round-robin and processed one 32-bit word per cycle. Results are returned with a done pulse. It sits between the round controller / key scheduler and the shared S-box resource in the AES-256 UART core, replacing the 20 S-box instances that dedicated lanes would need.

## Interface
- `LANES`, 4: S-box instances, i.e. bytes processed per beat; fixed at 4; state beats = 16/LANES.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `st_req`  in  1  state SubBytes request, level; held until `st_ack`.
- `st_in`  in  128  state bytes; byte i = `st_in[8i+7:8i]`; sampled at grant edge only.
- `st_ack`  out  1  one-cycle pulse: state request captured.
- `st_done`  out  1  one-cycle pulse: `st_out` valid.
- `st_out`  out  128  byte i = S(`st_in` byte i); held until next state completion.
- `ks_req`  in  1  key SubWord request, level; held until `ks_ack`.
- `ks_in`  in  32  key word; byte j = `ks_in[8j+7:8j]`.
- `ks_ack`  out  1  one-cycle pulse: key request captured.
- `ks_done`  out  1  one-cycle pulse: `ks_out` valid.
- `ks_out`  out  32  byte j = S(`ks_in` byte j); held until next key completion.
- `busy`  out  1  high whenever the FSM is not IDLE.

## Operation
- FSM states: IDLE, ST_RUN (beat counter 0..3), KS_RUN (single beat).
- In IDLE at an edge:
  - If only `st_req` is high: capture `st_in` into a 128-bit buffer, set beat=0, go to ST_RUN, `st_ack`=1 next cycle.
  - If only `ks_req` is high: capture `ks_in`, go to KS_RUN, `ks_ack`=1 next cycle.
- Both requests high in IDLE: grant the requester not granted last (`last_grant` flag). `last_grant` resets to KS, so the first conflict goes to state.
- ST_RUN: the lanes are fed buffer word `beat` (bytes 4·beat..4·beat+3). Each edge writes the result into the same word of the `st_out` register and increments beat. After beat 3 is written: `st_done`=1 for one cycle, FSM goes to IDLE.
- KS_RUN: the lanes are fed the key buffer. The next edge writes `ks_out`, pulses `ks_done` and returns to IDLE.
- Requests arriving while not in IDLE wait (level-held). They are sampled only in IDLE. No queuing beyond the level request.
- A requester must drop `req` in the cycle `ack` is high; a `req` still high at the next IDLE edge is treated as a new request.
- Lane input mux is driven only by FSM/beat; lanes see zero in IDLE.
- `st_out` word registers update only during ST_RUN. Partial words are visible internally but `st_out` is defined valid only at `st_done`.
- Reset (any time, including mid-run): FSM→IDLE, beat=0, `last_grant`=KS, buffers cleared, partial results discarded. All outputs are 0: `st_ack`, `st_done`, `ks_ack`, `ks_done`, `busy`, `st_out`, `ks_out`.

## Timing
- State request: capture edge E0. `st_ack` and `busy` are high E0→E1. Words 0..3 are written at E1..E4. `st_done` is high E4→E5. `busy` falls after E4. Earliest next capture is E5.
- State latency is 4 cycles capture→done. Throughput is one state per 5 cycles.
- Key request: capture E0, `ks_ack` high E0→E1, `ks_out` written and `ks_done` high E1→E2. Earliest next capture is E2.
- Simultaneous requests in IDLE: loser waits. It is granted at the first IDLE edge after the winner's done edge (E5 or E2).
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `aes_sbox_pkg`: `LANES`, `ST_BEATS`=16/LANES, FSM state encoding (IDLE/ST_RUN/KS_RUN), grant encoding (GRANT_ST/GRANT_KS), byte/word width constants.
- One sub-module: `sbox_lane4`, four existing `sbox` instances on a 32-bit word, purely combinational.
- FSM, arbiter, buffers and output registers live in `sbox_scheduler`.

## Test plan
- Reset, then `st_req` with `st_in`=all 00 → `st_ack` one cycle after capture, `st_done` 4 cycles after capture, `st_out`=all 63, `busy` high exactly 4 cycles.
- `ks_req`, `ks_in`=32'h53_01_FF_00 → `ks_done` 1 cycle after capture, `ks_out`=32'hED_7C_16_63.
- `st_req` and `ks_req` raised in the same cycle, twice in a row → first pair: state served first, key captured at E5. Second pair: key served first.
- `st_in` bytes 00..0F → `st_out` = 63 7C 77 7B F2 6B 6F C5 30 01 67 2B FE D7 AB 76 (byte 0 first). Change `st_in` after ack → result unaffected.
- Assert `reset` at beat 2 of a state run → all outputs 0 immediately, no `st_done`. A new request after release completes correctly.
- `ks_req` held high while a state run is in progress → `ks_ack` only after `st_done`, at the first IDLE edge.
